// File: rtl/ahbl_dffram_ctrl.sv
// rtl/ahbl_dffram_ctrl.sv - AHB-Lite subordinate front end for a single-port DFF RAM
module ahbl_dffram_ctrl #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          SRAM_EN,
  output logic [3:0]    SRAM_WE,
  output logic [AW-1:0] SRAM_A,
  output logic [31:0]   SRAM_DI,
  input  logic [31:0]   SRAM_DO
);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_e;

  state_e        state_q, state_d;

  logic          xfer, bad, err_ap, rd_ap, wr_ap;
  logic [3:0]    ap_lanes;
  logic [AW-1:0] ap_addr;

  // write data phase bookkeeping (address captured in the address phase)
  logic          wph_q;
  logic [AW-1:0] wa_q;
  logic [3:0]    wl_q;

  // one-entry write buffer used when a read address phase steals the port
  logic          buf_v_q, buf_v_d;
  logic [AW-1:0] buf_a_q, buf_a_d;
  logic [3:0]    buf_l_q, buf_l_d;
  logic [31:0]   buf_d_q, buf_d_d;

  // lanes of the read data phase that come from the buffer instead of the RAM
  logic [3:0]    fwd_m_q, fwd_m_d;
  logic [31:0]   fwd_d_q, fwd_d_d;

  // upper address bits alias by design and HTRANS[0] has no meaning here
  logic          unused_bits;
  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  assign xfer    = HSEL & HREADY & HTRANS[1];
  assign bad     = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (|HADDR[1:0]));
  assign err_ap  = xfer & bad & ~HRESET;
  assign rd_ap   = xfer & ~bad & ~HWRITE & ~HRESET;
  assign wr_ap   = xfer & ~bad & HWRITE & ~HRESET;
  assign ap_addr = HADDR[AW+1:2];

  // byte lanes selected by the transfer size and low address bits
  always_comb begin
    ap_lanes = 4'b0000;
    case (HSIZE)
      3'd0:    ap_lanes = 4'b0001 << HADDR[1:0];
      3'd1:    ap_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    ap_lanes = 4'b1111;
      default: ap_lanes = 4'b0000;
    endcase
  end

  // error response state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_OKAY;
    else        state_q <= state_d;
  end

  // two-cycle ERROR sequence; a good transfer seen in ERR2 proceeds normally
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_OKAY: begin
        if (err_ap) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = 1'b1;
        state_d = err_ap ? ST_ERR1 : ST_OKAY;
      end
      default: state_d = ST_OKAY;
    endcase
  end

  // buffer fill/drain and forwarding capture for the next read data phase
  always_comb begin
    buf_v_d = buf_v_q;
    buf_a_d = buf_a_q;
    buf_l_d = buf_l_q;
    buf_d_d = buf_d_q;
    if (wph_q && rd_ap) begin
      buf_v_d = 1'b1;
      buf_a_d = wa_q;
      buf_l_d = wl_q;
      buf_d_d = HWDATA;
    end else if (!rd_ap && !wph_q) begin
      buf_v_d = 1'b0;
    end
    fwd_m_d = 4'b0000;
    fwd_d_d = buf_d_d;
    if (rd_ap && buf_v_d && (buf_a_d == ap_addr)) fwd_m_d = buf_l_d;
  end

  // SRAM port arbitration: read address, then direct write, then drain
  always_comb begin
    SRAM_EN = 1'b0;
    SRAM_WE = 4'b0000;
    SRAM_A  = ap_addr;
    SRAM_DI = HWDATA;
    if (!HRESET) begin
      if (rd_ap) begin
        SRAM_EN = 1'b1;
      end else if (wph_q) begin
        SRAM_EN = 1'b1;
        SRAM_WE = wl_q;
        SRAM_A  = wa_q;
      end else if (buf_v_q) begin
        SRAM_EN = 1'b1;
        SRAM_WE = buf_l_q;
        SRAM_A  = buf_a_q;
        SRAM_DI = buf_d_q;
      end
    end
  end

  // pipeline registers; reset drops any in-flight phase and buffered write
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wph_q   <= 1'b0;
      wa_q    <= '0;
      wl_q    <= 4'b0000;
      buf_v_q <= 1'b0;
      buf_a_q <= '0;
      buf_l_q <= 4'b0000;
      buf_d_q <= 32'h0;
      fwd_m_q <= 4'b0000;
      fwd_d_q <= 32'h0;
    end else begin
      wph_q   <= wr_ap;
      if (wr_ap) begin
        wa_q <= ap_addr;
        wl_q <= ap_lanes;
      end
      buf_v_q <= buf_v_d;
      buf_a_q <= buf_a_d;
      buf_l_q <= buf_l_d;
      buf_d_q <= buf_d_d;
      fwd_m_q <= fwd_m_d;
      fwd_d_q <= fwd_d_d;
    end
  end

  // read data merges forwarded buffer lanes over the RAM output
  always_comb begin
    HRDATA = SRAM_DO;
    for (int i = 0; i < 4; i++) begin
      if (fwd_m_q[i]) HRDATA[8*i +: 8] = fwd_d_q[8*i +: 8];
    end
  end

  // a write address phase always drains the buffer, so these never overlap
  always_ff @(posedge HCLK) begin
    if (!HRESET) assert (!(wph_q && buf_v_q && !rd_ap));
  end

endmodule

// File: doc/ahbl_dffram_ctrl.md
AHBL_DFFRAM_CTRL -- requirements
Module: ahbl_dffram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, SRAM depth in 32-bit words; power of two, 32..4096; AW = log2(DEPTH).
REQ-002 SHALL run on one clock; reset is synchronous and active-high.
REQ-003 SHALL have port HCLK  in  1  clock, all state on rising edge.
REQ-004 SHALL have port HRESET  in  1  synchronous active-high reset.
REQ-005 SHALL have AHB-Lite subordinate ports:
- HSEL  in  1
- HADDR  in  32
- HTRANS  in  2
- HWRITE  in  1
- HSIZE  in  3
- HREADY  in  1
- HWDATA  in  32
- HREADYOUT  out  1
- HRESP  out  1
- HRDATA  out  32
REQ-006 SHALL have single-port SRAM ports; the SRAM captures these on the rising edge; read data is valid on SRAM_DO the cycle after a read:
- SRAM_EN  out  1
- SRAM_WE  out  4, byte write enables
- SRAM_A  out  AW, word address
- SRAM_DI  out  32
- SRAM_DO  in  32

Function
REQ-007 A valid transfer SHALL be HSEL & HREADY & HTRANS[1]; all other cycles are idle.
REQ-008 Byte lanes SHALL be derived from HSIZE and HADDR[1:0]:
- size 0: lane HADDR[1:0]
- size 1: lanes {2*HADDR[1], 2*HADDR[1]+1}
- size 2: all four lanes
REQ-009 SRAM word address SHALL be HADDR[AW+1:2]; HADDR[31:AW+2] are ignored, so addresses alias.
REQ-010 A transfer with HSIZE>2, or misaligned (size 1 & HADDR[0]; size 2 & HADDR[1:0]!=0), SHALL produce the two-cycle ERROR response and no SRAM access.
- FSM states: OKAY -> ERR1 -> ERR2 -> OKAY.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- OKAY: HREADYOUT=1, HRESP=0.
REQ-011 A valid transfer sampled in ERR2 SHALL be processed normally.
REQ-012 All OKAY transfers SHALL complete with zero wait states.
REQ-013 A read address phase SHALL assert SRAM_EN=1, SRAM_WE=0 and the address in the same cycle; HRDATA SHALL be valid in the following (data-phase) cycle.
REQ-014 SRAM port priority per cycle SHALL be:
- 1: read address phase
- 2: direct write of the current write data phase
- 3: drain of the write buffer
REQ-015 In a write data phase with no concurrent read address phase, the write SHALL go directly: SRAM_EN=1, SRAM_WE=lanes, SRAM_A=registered address, SRAM_DI=HWDATA.
REQ-016 A write data phase concurrent with a read address phase SHALL be stored in a one-entry buffer {word address, lanes, data, valid}.
REQ-017 The buffer SHALL drain in the first cycle with no read address phase; valid clears on drain.
REQ-018 A direct write and a buffer drain never coincide, because any write address phase drains the buffer; an assertion SHALL flag a violation.
REQ-019 Read forwarding: at the end of a read address phase, if the buffer (including an entry written that cycle) is valid with a matching word address, its lanes and data SHALL be registered. HRDATA SHALL take those lanes from the registered buffer data and the remaining lanes from SRAM_DO.
REQ-020 SRAM_DI SHALL carry full HWDATA; unselected lanes SHALL be masked only by SRAM_WE.
REQ-021 When SRAM_EN=0, SRAM_WE SHALL be 0.

Reset
REQ-022 On HRESET high at a clock edge:
- HREADYOUT=1, HRESP=0, FSM=OKAY.
- SRAM_EN=0, SRAM_WE=0.
- Buffer valid=0; forwarding mask=0, so HRDATA=SRAM_DO.
- Any in-flight phase is dropped.
REQ-023 Reset mid-operation SHALL discard a buffered, undrained write; no SRAM write occurs in the reset cycle.

Verification
REQ-024 Word write 0xDEADBEEF @0x10, then read @0x10 after idle -> direct write SRAM_WE=0xF A=4; read HRDATA=0xDEADBEEF, zero wait states.
REQ-025 Write 0x11223344 @0x20 immediately followed by read @0x20 -> write buffered; HRDATA=0x11223344 via forwarding; drain next idle cycle writes A=8.
REQ-026 Byte write 0xAB @0x21 (HWDATA=0x0000AB00), then word read @0x20 with old word 0x11223344 -> SRAM_WE=0x2; HRDATA=0x1122AB44.
REQ-027 Halfword access @0x31 -> HREADYOUT 0 then 1 with HRESP=1 both cycles; SRAM_EN stays 0.
REQ-028 Write @0x40 followed by reads R,R,R, with HRESET asserted on the 2nd read -> buffer discarded; a later read @0x40 returns the pre-write value.
REQ-029 DEPTH=32: write @0x80 then read @0x00 -> aliasing; read returns the value written @0x80.
